tdm_demux_2ch: RTL and testbench

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 select-muxing stage. It takes one interleaved word stream in which channel 0 and channel 1 occupy alternate valid beats, with a frame marker on every channel-0 beat. It tracks slot alignment, steers each beat into its own registered output, signals completed channel pairs and flags framing errors. It sits downstream of the link or channel that carries the muxed stream.

---
 rtl/tdm_pkg.sv | 16 +
 rtl/tdm_slot_tracker.sv | 64 ++++++
 rtl/tdm_demux_2ch.sv | 72 +++++++
 tb/tb_tdm_demux_2ch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the two-channel TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_CH = 2;

  typedef enum logic [1:0] {
    StUnsync = 2'd0,
    StExpCh1 = 2'd1,
    StExpCh0 = 2'd2
  } slot_state_e;

  function automatic logic is_synced(slot_state_e s);
    return s != StUnsync;
  endfunction

endpackage

// File: rtl/tdm_slot_tracker.sv
// Slot-alignment FSM: decodes each valid beat into a channel capture strobe or a framing error.
module tdm_slot_tracker
  import tdm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic sof_i,
  output logic cap_ch0_o,
  output logic cap_ch1_o,
  output logic sync_o,
  output logic frame_err_o
);

  slot_state_e state_q, state_d;

  always_comb begin
    state_d     = state_q;
    cap_ch0_o   = 1'b0;
    cap_ch1_o   = 1'b0;
    frame_err_o = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        StUnsync: begin
          if (sof_i) begin
            cap_ch0_o = 1'b1;
            state_d   = StExpCh1;
          end
        end
        StExpCh1: begin
          if (sof_i) begin
            // Channel-1 beat was dropped: resync on this new frame start.
            frame_err_o = 1'b1;
            cap_ch0_o   = 1'b1;
          end else begin
            cap_ch1_o = 1'b1;
            state_d   = StExpCh0;
          end
        end
        StExpCh0: begin
          if (sof_i) begin
            cap_ch0_o = 1'b1;
            state_d   = StExpCh1;
          end else begin
            frame_err_o = 1'b1;
            state_d     = StUnsync;
          end
        end
        default: state_d = StUnsync;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StUnsync;
    end else begin
      state_q <= state_d;
    end
  end

  assign sync_o = is_synced(state_q);

endmodule

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer top: registered channel words, pulses and sync.
// Optional saturating framing-error counter enabled by TDM_DEMUX_ERR_CNT_EN.
module tdm_demux_2ch
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  output logic [DATA_W-1:0] ch0_out,
  output logic [DATA_W-1:0] ch1_out,
  output logic              ch0_valid_out,
  output logic              ch1_valid_out,
  output logic              pair_valid_out,
  output logic              sync_out,
  output logic              frame_err_out
`ifdef TDM_DEMUX_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0] err_cnt_out
`endif
);

  logic cap_ch0, cap_ch1, frame_err;
  logic [DATA_W-1:0] ch_q [NUM_CH];

  tdm_slot_tracker u_slot_tracker (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .valid_i     (valid_in),
    .sof_i       (sof_in),
    .cap_ch0_o   (cap_ch0),
    .cap_ch1_o   (cap_ch1),
    .sync_o      (sync_out),
    .frame_err_o (frame_err)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ch_q[0]        <= '0;
      ch_q[1]        <= '0;
      ch0_valid_out  <= 1'b0;
      ch1_valid_out  <= 1'b0;
      pair_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      if (cap_ch0) ch_q[0] <= data_in;
      if (cap_ch1) ch_q[1] <= data_in;
      ch0_valid_out  <= cap_ch0;
      ch1_valid_out  <= cap_ch1;
      // A channel-1 capture always closes a frame opened by a channel-0 capture.
      pair_valid_out <= cap_ch1;
      frame_err_out  <= frame_err;
    end
  end

  assign ch0_out = ch_q[0];
  assign ch1_out = ch_q[1];

`ifdef TDM_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_cnt_out <= '0;
    end else if (frame_err && (err_cnt_out != {ERR_CNT_W{1'b1}})) begin
      err_cnt_out <= err_cnt_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Directed self-checking bench for tdm_demux_2ch; also covers the error counter when enabled.
module tb_tdm_demux_2ch;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ERR_CNT_W = 2;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_out;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              sof_in;
  logic [DATA_W-1:0] ch0_out, ch1_out;
  logic              ch0_valid_out, ch1_valid_out, pair_valid_out, sync_out, frame_err_out;

  int total = 0;
  int bad   = 0;

  // Row: reset, valid, sof, data, expected {ch0_v, ch1_v, pair_v, frame_err, sync}, {ch0, ch1}
  typedef struct packed {
    logic        r;
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic [4:0]  fl;
    logic [15:0] dat;
  } row_t;

  wire [4:0]  flags = {ch0_valid_out, ch1_valid_out, pair_valid_out, frame_err_out, sync_out};
  wire [15:0] chans = {ch0_out, ch1_out};

  always #5 clk_in = ~clk_in;

  tdm_demux_2ch #(
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .sof_in         (sof_in),
    .ch0_out        (ch0_out),
    .ch1_out        (ch1_out),
    .ch0_valid_out  (ch0_valid_out),
    .ch1_valid_out  (ch1_valid_out),
    .pair_valid_out (pair_valid_out),
    .sync_out       (sync_out),
    .frame_err_out  (frame_err_out)
`ifdef TDM_DEMUX_ERR_CNT_EN
    , .err_cnt_out  (err_cnt_out)
`endif
  );

  task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d);
    rst_in   = r;
    valid_in = v;
    sof_in   = s;
    data_in  = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
      total++;
      if (flags !== 5'b00000 || chans !== 16'h0000) begin
        bad++;
        $display("FAIL reset[%0d] flags=%b data=%h want flags=00000 data=0000", i, flags, chans);
      end
`ifdef TDM_DEMUX_ERR_CNT_EN
      total++;
      if (err_cnt_out !== 2'd0) begin
        bad++;
        $display("FAIL reset_cnt[%0d] got=%0d want=0", i, err_cnt_out);
      end
`endif
    end
  endtask

  task automatic test_clean_frames();
    row_t rows [4];
    rows = '{'{1'b0, 1'b1, 1'b1, 8'h11, 5'b10001, 16'h1100},
             '{1'b0, 1'b1, 1'b0, 8'h22, 5'b01101, 16'h1122},
             '{1'b0, 1'b1, 1'b1, 8'h33, 5'b10001, 16'h3322},
             '{1'b0, 1'b1, 1'b0, 8'h44, 5'b01101, 16'h3344}};
    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].v, rows[i].s, rows[i].d);
      total++;
      if (flags !== rows[i].fl || chans !== rows[i].dat) begin
        bad++;
        $display("FAIL clean[%0d] flags=%b data=%h want flags=%b data=%h",
                 i, flags, chans, rows[i].fl, rows[i].dat);
      end
    end
  endtask

  task automatic test_presync_garbage();
    row_t rows [5];
    rows = '{'{1'b1, 1'b0, 1'b0, 8'h00, 5'b00000, 16'h0000},
             '{1'b0, 1'b1, 1'b0, 8'hAA, 5'b00000, 16'h0000},
             '{1'b0, 1'b1, 1'b0, 8'hBB, 5'b00000, 16'h0000},
             '{1'b0, 1'b1, 1'b1, 8'h01, 5'b10001, 16'h0100},
             '{1'b0, 1'b1, 1'b0, 8'h02, 5'b01101, 16'h0102}};
    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].v, rows[i].s, rows[i].d);
      total++;
      if (flags !== rows[i].fl || chans !== rows[i].dat) begin
        bad++;
        $display("FAIL presync[%0d] flags=%b data=%h want flags=%b data=%h",
                 i, flags, chans, rows[i].fl, rows[i].dat);
      end
    end
  endtask

  task automatic test_missing_ch1();
    row_t rows [3];
    rows = '{'{1'b0, 1'b1, 1'b1, 8'h10, 5'b10001, 16'h1002},
             '{1'b0, 1'b1, 1'b1, 8'h20, 5'b10011, 16'h2002},
             '{1'b0, 1'b1, 1'b0, 8'h30, 5'b01101, 16'h2030}};
    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].v, rows[i].s, rows[i].d);
      total++;
      if (flags !== rows[i].fl || chans !== rows[i].dat) begin
        bad++;
        $display("FAIL missing_ch1[%0d] flags=%b data=%h want flags=%b data=%h",
                 i, flags, chans, rows[i].fl, rows[i].dat);
      end
    end
`ifdef TDM_DEMUX_ERR_CNT_EN
    total++;
    if (err_cnt_out !== 2'd1) begin
      bad++;
      $display("FAIL missing_ch1_cnt got=%0d want=1", err_cnt_out);
    end
`endif
  endtask

  task automatic test_lost_sof();
    row_t rows [4];
    rows = '{'{1'b0, 1'b1, 1'b1, 8'h5A, 5'b10001, 16'h5A30},
             '{1'b0, 1'b1, 1'b0, 8'h5B, 5'b01101, 16'h5A5B},
             '{1'b0, 1'b1, 1'b0, 8'h55, 5'b00010, 16'h5A5B},
             '{1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 16'h5A5B}};
    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].v, rows[i].s, rows[i].d);
      total++;
      if (flags !== rows[i].fl || chans !== rows[i].dat) begin
        bad++;
        $display("FAIL lost_sof[%0d] flags=%b data=%h want flags=%b data=%h",
                 i, flags, chans, rows[i].fl, rows[i].dat);
      end
    end
`ifdef TDM_DEMUX_ERR_CNT_EN
    total++;
    if (err_cnt_out !== 2'd2) begin
      bad++;
      $display("FAIL lost_sof_cnt got=%0d want=2", err_cnt_out);
    end
`endif
  endtask

  task automatic test_midframe_reset();
    row_t rows [6];
    // Gap cycles carry sof/data that must be ignored; the reset cycle carries a ch1-like beat.
    rows = '{'{1'b0, 1'b1, 1'b1, 8'h66, 5'b10001, 16'h665B},
             '{1'b0, 1'b0, 1'b1, 8'hE1, 5'b00001, 16'h665B},
             '{1'b0, 1'b0, 1'b0, 8'hE2, 5'b00001, 16'h665B},
             '{1'b0, 1'b0, 1'b1, 8'hE3, 5'b00001, 16'h665B},
             '{1'b1, 1'b1, 1'b0, 8'h99, 5'b00000, 16'h0000},
             '{1'b0, 1'b1, 1'b0, 8'h77, 5'b00000, 16'h0000}};
    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].v, rows[i].s, rows[i].d);
      total++;
      if (flags !== rows[i].fl || chans !== rows[i].dat) begin
        bad++;
        $display("FAIL midframe[%0d] flags=%b data=%h want flags=%b data=%h",
                 i, flags, chans, rows[i].fl, rows[i].dat);
      end
    end
  endtask

`ifdef TDM_DEMUX_ERR_CNT_EN
  task automatic test_err_cnt_saturate();
    logic [1:0] want [5];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 8'(8'h81 + i));
      total++;
      if (err_cnt_out !== want[i] || frame_err_out !== (i != 0)) begin
        bad++;
        $display("FAIL err_cnt[%0d] cnt=%0d err=%b want cnt=%0d err=%b",
                 i, err_cnt_out, frame_err_out, want[i], (i != 0));
      end
    end
  endtask
`endif

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    data_in  = '0;
    test_reset();
    test_clean_frames();
    test_presync_garbage();
    test_missing_ch1();
    test_lost_sof();
    test_midframe_reset();
`ifdef TDM_DEMUX_ERR_CNT_EN
    test_err_cnt_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
